fifo_rd_adapter: RTL



---
 rtl/fifo_rd_adapter_pkg.sv | 7 +
 rtl/fifo_rd_adapter_if.sv | 19 +
 rtl/fifo_skid_buf.sv | 35 +++
 rtl/fifo_rd_adapter.sv | 44 ++++
 4 files changed

// File: rtl/fifo_rd_adapter_pkg.sv
// fifo_rd_adapter_pkg: shared defaults and types for the FIFO read adapter
package fifo_rd_adapter_pkg;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_SKID_DEPTH = 3;
  typedef logic [DEF_FIFO_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, PARTIAL, FULL} buf_state_t;
endpackage

// File: rtl/fifo_rd_adapter_if.sv
// fifo_rd_adapter_if: FIFO read port plus output stream bundle
// stall_count/starve_count exist only when FIFO_RD_STALL_CNT_EN is defined
interface fifo_rd_adapter_if import fifo_rd_adapter_pkg::*; #(parameter int W = DEF_FIFO_WIDTH);
  logic fifo_empty, fifo_underflow, fifo_rd_en, m_valid, m_ready, underflow_err;
  logic [W-1:0] fifo_data_out, m_data;
  logic [15:0] pop_count;
`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0] stall_count, starve_count;
  modport master (input fifo_empty, fifo_underflow, fifo_data_out, m_ready,
                  output fifo_rd_en, m_valid, m_data, pop_count, underflow_err, stall_count, starve_count);
  modport slave (output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
                 input fifo_rd_en, m_valid, m_data, pop_count, underflow_err, stall_count, starve_count);
`else
  modport master (input fifo_empty, fifo_underflow, fifo_data_out, m_ready,
                  output fifo_rd_en, m_valid, m_data, pop_count, underflow_err);
  modport slave (output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
                 input fifo_rd_en, m_valid, m_data, pop_count, underflow_err);
`endif
endinterface

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: circular skid storage with explicit-compare pointer wrap
module fifo_skid_buf import fifo_rd_adapter_pkg::*; #(
  parameter int W = DEF_FIFO_WIDTH,
  parameter int D = DEF_SKID_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [W-1:0]           wdata,
  input  logic                   rd,
  output logic [$clog2(D+1)-1:0] occ,
  output buf_state_t             state,
  output logic [W-1:0]           rdata
);
  localparam int PW = $clog2(D);
  localparam int OW = $clog2(D+1);
  logic [W-1:0] mem [D];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr == PW'(D-1) ? '0 : wr_ptr + 1'b1;
      end
      if (rd) rd_ptr <= rd_ptr == PW'(D-1) ? '0 : rd_ptr + 1'b1;
      occ <= occ + OW'(wr) - OW'(rd);
    end
  assign state = occ == '0 ? IDLE : occ == OW'(D) ? FULL : PARTIAL;
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter: drains the FIFO read port into a valid/ready stream at one word per cycle
// optional FIFO_RD_STALL_CNT_EN adds saturating stall/starve counters
module fifo_rd_adapter import fifo_rd_adapter_pkg::*; #(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
  input logic clk,
  input logic rst_n,
  fifo_rd_adapter_if.master bus
);
  logic inflight, pop;
  logic [$clog2(SKID_DEPTH+1)-1:0] occ;
  buf_state_t state;
  logic [FIFO_WIDTH-1:0] rdata;
  fifo_skid_buf #(.W(FIFO_WIDTH), .D(SKID_DEPTH)) u_buf (
    .clk(clk), .rst_n(rst_n), .wr(inflight), .wdata(bus.fifo_data_out),
    .rd(pop), .occ(occ), .state(state), .rdata(rdata)
  );
  // every in-flight read already owns a slot, so capture can never overflow
  assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && (int'(occ) + int'(inflight) < SKID_DEPTH);
  assign bus.m_valid = state != IDLE;
  assign bus.m_data = rdata;
  assign pop = bus.m_valid && bus.m_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight <= 1'b0;
      bus.pop_count <= '0;
      bus.underflow_err <= 1'b0;
    end else begin
      inflight <= bus.fifo_rd_en;
      bus.pop_count <= bus.pop_count + 16'(pop);
      bus.underflow_err <= bus.underflow_err | bus.fifo_underflow;
    end
`ifdef FIFO_RD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.stall_count <= '0;
      bus.starve_count <= '0;
    end else begin
      bus.stall_count <= bus.stall_count + 16'(bus.m_valid && !bus.m_ready && bus.stall_count != 16'hFFFF);
      bus.starve_count <= bus.starve_count + 16'(state == IDLE && !inflight && bus.fifo_empty && bus.starve_count != 16'hFFFF);
    end
`endif
endmodule
